// File: rtl/led_stream_rx.sv
// rtl/led_stream_rx.sv - LED serial stream receiver: oversampled SCLK/LAT/SDO deserializer
// Emits lane-parallel words over valid/ready and reports per-latch bit counts and framing errors.
module led_stream_rx #(
  parameter int NUM_SHIFT = 4,
  parameter int WORD_BITS = 16,
  parameter int IDX_W     = 7
) (
  input  logic                           spiClk,
  input  logic                           nReset,
  input  logic                           enable,
  input  logic                           SCLK,
  input  logic [NUM_SHIFT-1:0]           SDO,
  input  logic                           LAT,
  output logic [NUM_SHIFT*WORD_BITS-1:0] wordData,
  output logic [IDX_W-1:0]               wordIndex,
  output logic                           wordValid,
  input  logic                           wordReady,
  output logic                           latchPulse,
  output logic [15:0]                    latchBits,
  output logic                           frameErr,
  output logic                           overflow,
  input  logic                           clearErr
);

  localparam int IW_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [IW_W-1:0] IW_LAST = IW_W'(WORD_BITS - 1);
  localparam int DW = NUM_SHIFT * WORD_BITS;

  typedef enum logic {ARM, SHIFT} state_t;

  // Input synchronizers; SDO shares the SCLK pipeline depth so data stays aligned with its edge.
  logic                 sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic                 lat_meta_q, lat_sync_q, lat_prev_q;
  logic [NUM_SHIFT-1:0] sdo_meta_q, sdo_sync_q;

  state_t               state_q, state_d;
  logic [DW-1:0]        sh_q, sh_d;
  logic [15:0]          bit_cnt_q, bit_cnt_d;
  logic [IW_W-1:0]      iw_q, iw_d;
  logic [IDX_W-1:0]     word_cnt_q, word_cnt_d;
  logic [DW-1:0]        word_data_q, word_data_d;
  logic [IDX_W-1:0]     word_index_q, word_index_d;
  logic                 word_valid_q, word_valid_d;
  logic                 latch_pulse_q, latch_pulse_d;
  logic [15:0]          latch_bits_q, latch_bits_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overflow_q, overflow_d;

  logic                 sclk_rise, lat_rise;
  logic [DW-1:0]        shifted;
  logic [15:0]          bit_inc;
  logic [IW_W-1:0]      iw_inc;
  logic                 word_done, new_word, frame_set, ovf_set;

  always_comb begin
    sclk_rise = sclk_sync_q & ~sclk_prev_q;
    lat_rise  = lat_sync_q & ~lat_prev_q;

    shifted = '0;
    for (int i = 0; i < NUM_SHIFT; i++) begin
      shifted[i*WORD_BITS +: WORD_BITS] = {sh_q[i*WORD_BITS +: WORD_BITS-1], sdo_sync_q[i]};
    end

    bit_inc   = (sclk_rise && bit_cnt_q != 16'hFFFF) ? bit_cnt_q + 16'd1 : bit_cnt_q;
    iw_inc    = sclk_rise ? ((iw_q == IW_LAST) ? '0 : iw_q + IW_W'(1)) : iw_q;
    word_done = sclk_rise && (iw_q == IW_LAST);

    state_d       = state_q;
    sh_d          = sh_q;
    bit_cnt_d     = bit_cnt_q;
    iw_d          = iw_q;
    word_cnt_d    = word_cnt_q;
    word_data_d   = word_data_q;
    word_index_d  = word_index_q;
    word_valid_d  = word_valid_q;
    latch_pulse_d = 1'b0;
    latch_bits_d  = latch_bits_q;
    new_word      = 1'b0;
    frame_set     = 1'b0;
    ovf_set       = 1'b0;

    case (state_q)
      ARM: begin
        sh_d       = '0;
        bit_cnt_d  = '0;
        iw_d       = '0;
        word_cnt_d = '0;
        if (enable && !lat_sync_q && !sclk_sync_q) state_d = SHIFT;
      end
      SHIFT: begin
        if (!enable) begin
          state_d    = ARM;
          sh_d       = '0;
          bit_cnt_d  = '0;
          iw_d       = '0;
          word_cnt_d = '0;
        end else begin
          if (sclk_rise) sh_d = shifted;
          bit_cnt_d = bit_inc;
          iw_d      = iw_inc;
          if (word_done) begin
            new_word   = 1'b1;
            word_cnt_d = word_cnt_q + IDX_W'(1);
          end
          // A coincident SCLK rise is already folded into bit_inc/iw_inc.
          if (lat_rise) begin
            latch_pulse_d = 1'b1;
            latch_bits_d  = bit_inc;
            frame_set     = (bit_inc == 16'd0) || (iw_inc != '0);
            sh_d          = '0;
            bit_cnt_d     = '0;
            iw_d          = '0;
            word_cnt_d    = '0;
          end
        end
      end
      default: state_d = ARM;
    endcase

    if (new_word) begin
      if (word_valid_q && !wordReady) begin
        ovf_set = 1'b1;
      end else begin
        word_data_d  = shifted;
        word_index_d = word_cnt_q;
        word_valid_d = 1'b1;
      end
    end else if (word_valid_q && wordReady) begin
      word_valid_d = 1'b0;
    end

    frame_err_d = (frame_err_q & ~clearErr) | frame_set;
    overflow_d  = (overflow_q & ~clearErr) | ovf_set;
  end

  always_ff @(posedge spiClk) begin
    if (!nReset) begin
      sclk_meta_q   <= 1'b0;
      sclk_sync_q   <= 1'b0;
      sclk_prev_q   <= 1'b0;
      lat_meta_q    <= 1'b0;
      lat_sync_q    <= 1'b0;
      lat_prev_q    <= 1'b0;
      sdo_meta_q    <= '0;
      sdo_sync_q    <= '0;
      state_q       <= ARM;
      sh_q          <= '0;
      bit_cnt_q     <= '0;
      iw_q          <= '0;
      word_cnt_q    <= '0;
      word_data_q   <= '0;
      word_index_q  <= '0;
      word_valid_q  <= 1'b0;
      latch_pulse_q <= 1'b0;
      latch_bits_q  <= '0;
      frame_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      sclk_meta_q   <= SCLK;
      sclk_sync_q   <= sclk_meta_q;
      sclk_prev_q   <= sclk_sync_q;
      lat_meta_q    <= LAT;
      lat_sync_q    <= lat_meta_q;
      lat_prev_q    <= lat_sync_q;
      sdo_meta_q    <= SDO;
      sdo_sync_q    <= sdo_meta_q;
      state_q       <= state_d;
      sh_q          <= sh_d;
      bit_cnt_q     <= bit_cnt_d;
      iw_q          <= iw_d;
      word_cnt_q    <= word_cnt_d;
      word_data_q   <= word_data_d;
      word_index_q  <= word_index_d;
      word_valid_q  <= word_valid_d;
      latch_pulse_q <= latch_pulse_d;
      latch_bits_q  <= latch_bits_d;
      frame_err_q   <= frame_err_d;
      overflow_q    <= overflow_d;
    end
  end

  assign wordData   = word_data_q;
  assign wordIndex  = word_index_q;
  assign wordValid  = word_valid_q;
  assign latchPulse = latch_pulse_q;
  assign latchBits  = latch_bits_q;
  assign frameErr   = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_led_stream_rx.sv
// tb/tb_led_stream_rx.sv - scoreboard bench for led_stream_rx
// Stimulus pushes expected words/latch records; a monitor pops and compares on each transfer or latchPulse.
module tb_led_stream_rx;

  logic        spiClk = 1'b0;
  logic        nReset = 1'b0;
  logic        enable = 1'b0;
  logic        SCLK = 1'b0;
  logic [3:0]  SDO = 4'h0;
  logic        LAT = 1'b0;
  logic [63:0] wordData;
  logic [6:0]  wordIndex;
  logic        wordValid;
  logic        wordReady = 1'b1;
  logic        latchPulse;
  logic [15:0] latchBits;
  logic        frameErr;
  logic        overflow;
  logic        clearErr = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [6:0]  idx;
    logic [63:0] data;
  } word_t;

  typedef struct packed {
    logic [15:0] bits;
    logic        ferr;
  } latch_t;

  word_t  exp_words[$];
  latch_t exp_latch[$];

  led_stream_rx dut (
    .spiClk(spiClk), .nReset(nReset), .enable(enable), .SCLK(SCLK), .SDO(SDO), .LAT(LAT),
    .wordData(wordData), .wordIndex(wordIndex), .wordValid(wordValid), .wordReady(wordReady),
    .latchPulse(latchPulse), .latchBits(latchBits), .frameErr(frameErr), .overflow(overflow),
    .clearErr(clearErr)
  );

  always #5 spiClk = ~spiClk;

  // Monitor samples 3 time units before the rising edge, after the negedge drives settle.
  initial begin
    word_t  w;
    latch_t l;
    forever begin
      @(negedge spiClk);
      #2;
      if (wordValid && wordReady) begin
        checks++;
        if (exp_words.size() == 0) begin
          failures++;
          $display("FAIL word_unexpected idx=%0d data=%h", wordIndex, wordData);
        end else begin
          w = exp_words.pop_front();
          if (wordIndex !== w.idx || wordData !== w.data) begin
            failures++;
            $display("FAIL word actual idx=%0d data=%h expected idx=%0d data=%h",
                     wordIndex, wordData, w.idx, w.data);
          end
        end
      end
      if (latchPulse) begin
        checks++;
        if (exp_latch.size() == 0) begin
          failures++;
          $display("FAIL latch_unexpected bits=%0d ferr=%0b", latchBits, frameErr);
        end else begin
          l = exp_latch.pop_front();
          if (latchBits !== l.bits || frameErr !== l.ferr) begin
            failures++;
            $display("FAIL latch actual bits=%0d ferr=%0b expected bits=%0d ferr=%0b",
                     latchBits, frameErr, l.bits, l.ferr);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [6:0] idx, input logic [63:0] data);
    word_t w;
    w.idx = idx;
    w.data = data;
    exp_words.push_back(w);
  endtask

  task automatic push_latch(input logic [15:0] bits, input logic ferr);
    latch_t l;
    l.bits = bits;
    l.ferr = ferr;
    exp_latch.push_back(l);
  endtask

  // SCLK period 8 spiClk: 4 low with SDO set, 4 high. Called at a negedge.
  task automatic send_bits(input int n, input logic [63:0] l0, input logic [63:0] l1,
                           input logic [63:0] l2, input logic [63:0] l3);
    for (int b = n - 1; b >= 0; b--) begin
      SCLK = 1'b0;
      SDO = {l3[b], l2[b], l1[b], l0[b]};
      repeat (4) @(negedge spiClk);
      SCLK = 1'b1;
      repeat (4) @(negedge spiClk);
    end
    SCLK = 1'b0;
  endtask

  task automatic pulse_lat();
    repeat (2) @(negedge spiClk);
    LAT = 1'b1;
    repeat (4) @(negedge spiClk);
    LAT = 1'b0;
    repeat (6) @(negedge spiClk);
  endtask

  task automatic clear_flags();
    @(negedge spiClk);
    clearErr = 1'b1;
    @(negedge spiClk);
    clearErr = 1'b0;
    @(negedge spiClk);
    #1;
    check("clear_frameErr", {63'd0, frameErr}, 64'd0);
    check("clear_overflow", {63'd0, overflow}, 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge spiClk);
    #1;
    check("rst_wordValid", {63'd0, wordValid}, 64'd0);
    check("rst_latchPulse", {63'd0, latchPulse}, 64'd0);
    check("rst_latchBits", {48'd0, latchBits}, 64'd0);
    check("rst_flags", {62'd0, frameErr, overflow}, 64'd0);
    check("rst_wordData", wordData, 64'd0);
    check("rst_wordIndex", {57'd0, wordIndex}, 64'd0);
    @(negedge spiClk);
    nReset = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge spiClk);

    // Basic 32-bit frame
    push_word(7'd0, {16'hFFFF, 16'h1357, 16'h0F0F, 16'hA5A5});
    push_word(7'd1, {16'h0000, 16'h9BDF, 16'hF0F0, 16'h1234});
    push_latch(16'd32, 1'b0);
    send_bits(32, 64'hA5A5_1234, 64'h0F0F_F0F0, 64'h1357_9BDF, 64'hFFFF_0000);
    pulse_lat();

    // Framing: 20 bits
    push_word(7'd0, {16'hFFFF, 16'h0000, 16'h1234, 16'hABCD});
    push_latch(16'd20, 1'b1);
    send_bits(20, 64'hABCDE, 64'h12345, 64'h00000, 64'hFFFFF);
    pulse_lat();
    clear_flags();

    // Backpressure: 3 words with wordReady low
    wordReady = 1'b0;
    push_word(7'd0, {16'hDEAD, 16'h0000, 16'hAAAA, 16'h1111});
    push_latch(16'd48, 1'b0);
    send_bits(48, 64'h1111_2222_3333, 64'hAAAA_BBBB_CCCC, 64'h0, 64'hDEAD_BEEF_CAFE);
    repeat (6) @(negedge spiClk);
    #1;
    check("bp_valid_held", {63'd0, wordValid}, 64'd1);
    check("bp_data_held", wordData, {16'hDEAD, 16'h0000, 16'hAAAA, 16'h1111});
    check("bp_index_held", {57'd0, wordIndex}, 64'd0);
    check("bp_overflow", {63'd0, overflow}, 64'd1);
    pulse_lat();
    @(negedge spiClk);
    wordReady = 1'b1;
    @(negedge spiClk);
    #1;
    check("bp_valid_cleared", {63'd0, wordValid}, 64'd0);
    clear_flags();

    // Coincident 16th SCLK rise and LAT rise
    push_word(7'd0, {16'h7E7E, 16'h8000, 16'h0001, 16'hC3A5});
    push_latch(16'd16, 1'b0);
    @(negedge spiClk);
    send_bits(15, 64'hC3A5 >> 1, 64'h0001 >> 1, 64'h8000 >> 1, 64'h7E7E >> 1);
    SCLK = 1'b0;
    SDO = 4'b0011;
    repeat (4) @(negedge spiClk);
    SCLK = 1'b1;
    LAT = 1'b1;
    repeat (4) @(negedge spiClk);
    SCLK = 1'b0;
    LAT = 1'b0;
    repeat (8) @(negedge spiClk);

    // Arming: leave reset with SCLK and LAT high; activity before both go low is ignored
    nReset = 1'b0;
    enable = 1'b0;
    SCLK = 1'b1;
    LAT = 1'b1;
    SDO = 4'hF;
    repeat (3) @(negedge spiClk);
    nReset = 1'b1;
    repeat (5) @(negedge spiClk);
    enable = 1'b1;
    repeat (5) @(negedge spiClk);
    send_bits(3, 64'h7, 64'h7, 64'h7, 64'h7);
    repeat (4) @(negedge spiClk);
    LAT = 1'b0;
    repeat (6) @(negedge spiClk);
    push_word(7'd0, {16'h8001, 16'h0F0F, 16'hFFFF, 16'h5A5A});
    push_latch(16'd16, 1'b0);
    send_bits(16, 64'h5A5A, 64'hFFFF, 64'h0F0F, 64'h8001);
    pulse_lat();
    push_latch(16'd0, 1'b1);
    pulse_lat();
    clear_flags();

    // Reset mid-frame after 8 bits
    send_bits(8, 64'hFF, 64'hFF, 64'hFF, 64'hFF);
    nReset = 1'b0;
    repeat (3) @(negedge spiClk);
    #1;
    check("midrst_valid", {63'd0, wordValid}, 64'd0);
    check("midrst_latchBits", {48'd0, latchBits}, 64'd0);
    @(negedge spiClk);
    nReset = 1'b1;
    repeat (4) @(negedge spiClk);
    push_word(7'd0, {16'h6978, 16'h4B5A, 16'h2D3C, 16'h0F1E});
    push_latch(16'd16, 1'b0);
    send_bits(16, 64'h0F1E, 64'h2D3C, 64'h4B5A, 64'h6978);
    pulse_lat();

    repeat (10) @(negedge spiClk);
    #1;
    check("words_outstanding", 64'(exp_words.size()), 64'd0);
    check("latches_outstanding", 64'(exp_latch.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
